// File: rtl/pc_sequencer.sv
// Fetch sequencer: walks pc through BROM/RAM, loads the instruction register, and handles
// decode back-pressure, execute redirects, halt/resume and the BOOT -> RUN start-up.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instruction_binary,
    output logic [15:0] pc,
    output logic        execute_from_ram,
    input  logic        jump_valid,
    input  logic [15:0] jump_target,
    input  logic        jump_ram,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT    = 2'b00,
        RUN     = 2'b01,
        HALT    = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_d;
    logic        erm_d;
    logic [31:0] ir_d;
    logic [15:0] ir_pc_d;
    logic        ir_valid_d;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= BOOT;
            pc               <= 16'h0000;
            execute_from_ram <= 1'b0;
            ir               <= 32'h0000_0000;
            ir_pc            <= 16'h0000;
            ir_valid         <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc               <= pc_d;
            execute_from_ram <= erm_d;
            ir               <= ir_d;
            ir_pc            <= ir_pc_d;
            ir_valid         <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        erm_d      = execute_from_ram;
        ir_d       = ir;
        ir_pc_d    = ir_pc;
        // A handshake always retires the held instruction unless a fetch refills it below.
        ir_valid_d = ir_valid && !ir_ready;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (jump_valid) begin
                    pc_d       = jump_target;
                    erm_d      = jump_ram;
                    ir_valid_d = 1'b0;
                end else if (halt) begin
                    state_d = HALT;
                end else if (!ir_valid || ir_ready) begin
                    ir_d       = instruction_binary;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    pc_d       = pc + 16'h0001;
                end
            end
            HALT: begin
                if (jump_valid) begin
                    pc_d       = jump_target;
                    erm_d      = jump_ram;
                    ir_valid_d = 1'b0;
                end else if (resume && !halt) begin
                    state_d = RUN;
                end
            end
            default: begin
                // Unreachable encoding: recover straight into RUN without fetching.
                state_d = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with a behavioural BROM/RAM fetch model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instruction_binary;
    logic [15:0] pc;
    logic        execute_from_ram;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic        jump_ram = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b1;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // BROM word n = 0xA000_0000+n, RAM word n = 0xB000_0000+n
    assign instruction_binary = (execute_from_ram ? 32'hB000_0000 : 32'hA000_0000) + {16'h0000, pc};

    pc_sequencer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .instruction_binary (instruction_binary),
        .pc                 (pc),
        .execute_from_ram   (execute_from_ram),
        .jump_valid         (jump_valid),
        .jump_target        (jump_target),
        .jump_ram           (jump_ram),
        .halt               (halt),
        .resume             (resume),
        .ir                 (ir),
        .ir_pc              (ir_pc),
        .ir_valid           (ir_valid),
        .ir_ready           (ir_ready),
        .state              (state)
    );

    typedef struct {
        logic        rn;
        logic        jv;
        logic [15:0] jt;
        logic        jr;
        logic        hl;
        logic        rs;
        logic        rdy;
        logic [15:0] e_pc;
        logic        e_erm;
        logic [15:0] e_irpc;
        logic        e_iv;
        logic [1:0]  e_st;
        logic [31:0] e_ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rn, input logic jv, input logic [15:0] jt, input logic jr,
                       input logic hl, input logic rs, input logic rdy,
                       input logic [15:0] e_pc, input logic e_erm, input logic [15:0] e_irpc,
                       input logic e_iv, input logic [1:0] e_st, input logic [31:0] e_ir);
        vec_t v;
        v.rn = rn; v.jv = jv; v.jt = jt; v.jr = jr; v.hl = hl; v.rs = rs; v.rdy = rdy;
        v.e_pc = e_pc; v.e_erm = e_erm; v.e_irpc = e_irpc; v.e_iv = e_iv; v.e_st = e_st; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rn, input logic jv, input logic [15:0] jt, input logic jr,
                         input logic hl, input logic rs, input logic rdy);
        reset_n = rn; jump_valid = jv; jump_target = jt; jump_ram = jr;
        halt = hl; resume = rs; ir_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic [15:0] e_pc, input logic e_erm,
                             input logic [15:0] e_irpc, input logic e_iv, input logic [1:0] e_st,
                             input logic [31:0] e_ir);
        chk("pc", idx, {16'h0, pc}, {16'h0, e_pc});
        chk("execute_from_ram", idx, {31'h0, execute_from_ram}, {31'h0, e_erm});
        chk("ir_pc", idx, {16'h0, ir_pc}, {16'h0, e_irpc});
        chk("ir_valid", idx, {31'h0, ir_valid}, {31'h0, e_iv});
        chk("state", idx, {30'h0, state}, {30'h0, e_st});
        chk("ir", idx, ir, e_ir);
    endtask

    localparam logic [1:0] S_BOOT = 2'b00, S_RUN = 2'b01, S_HALT = 2'b10;

    initial begin
        //   rn jv jt       jr hl rs rdy  pc       erm irpc     iv st      ir
        // reset, with a jump request that must be ignored
        add(0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, S_BOOT, 32'h0000_0000);
        add(0, 1, 16'h5555, 1, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, S_BOOT, 32'h0000_0000);
        // BOOT edge, then consecutive BROM fetches 0..5
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, S_RUN,  32'h0000_0000);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 16'h0000, 1, S_RUN,  32'hA000_0000);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0002, 0, 16'h0001, 1, S_RUN,  32'hA000_0001);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0003, 0, 16'h0002, 1, S_RUN,  32'hA000_0002);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0004, 0, 16'h0003, 1, S_RUN,  32'hA000_0003);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0005, 0, 16'h0004, 1, S_RUN,  32'hA000_0004);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0006, 0, 16'h0005, 1, S_RUN,  32'hA000_0005);
        // decode stall for three cycles
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0006, 0, 16'h0005, 1, S_RUN,  32'hA000_0005);
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0006, 0, 16'h0005, 1, S_RUN,  32'hA000_0005);
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0006, 0, 16'h0005, 1, S_RUN,  32'hA000_0005);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0007, 0, 16'h0006, 1, S_RUN,  32'hA000_0006);
        // jump beats halt, flushes ir_valid even with ir_ready low
        add(1, 1, 16'h1234, 1, 1, 0, 0, 16'h1234, 1, 16'h0006, 0, S_RUN,  32'hA000_0006);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1235, 1, 16'h1234, 1, S_RUN,  32'hB000_1234);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1236, 1, 16'h1235, 1, S_RUN,  32'hB000_1235);
        // halt with ir unconsumed, drained in HALT, no fetch
        add(1, 0, 16'h0000, 0, 1, 0, 0, 16'h1236, 1, 16'h1235, 1, S_HALT, 32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1236, 1, 16'h1235, 0, S_HALT, 32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1236, 1, 16'h1235, 0, S_HALT, 32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1236, 1, 16'h1235, 0, S_HALT, 32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1236, 1, 16'h1235, 0, S_HALT, 32'hB000_1235);
        // halt+resume stays in HALT, resume alone returns to RUN
        add(1, 0, 16'h0000, 0, 1, 1, 1, 16'h1236, 1, 16'h1235, 0, S_HALT, 32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 1, 1, 16'h1236, 1, 16'h1235, 0, S_RUN,  32'hB000_1235);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h1237, 1, 16'h1236, 1, S_RUN,  32'hB000_1236);
        add(1, 0, 16'h0000, 0, 0, 1, 1, 16'h1238, 1, 16'h1237, 1, S_RUN,  32'hB000_1237);
        // reset during HALT with ir_valid=1 and a jump pending
        add(1, 0, 16'h0000, 0, 1, 0, 0, 16'h1238, 1, 16'h1237, 1, S_HALT, 32'hB000_1237);
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h1238, 1, 16'h1237, 1, S_HALT, 32'hB000_1237);
        add(0, 1, 16'hBEEF, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, S_BOOT, 32'h0000_0000);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, S_RUN,  32'h0000_0000);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0001, 0, 16'h0000, 1, S_RUN,  32'hA000_0000);
        // jump while halted keeps HALT, first fetch after resume is at the target in RAM
        add(1, 0, 16'h0000, 0, 1, 0, 1, 16'h0001, 0, 16'h0000, 0, S_HALT, 32'hA000_0000);
        add(1, 1, 16'h0100, 1, 0, 0, 1, 16'h0100, 1, 16'h0000, 0, S_HALT, 32'hA000_0000);
        add(1, 0, 16'h0000, 0, 0, 1, 1, 16'h0100, 1, 16'h0000, 0, S_RUN,  32'hA000_0000);
        add(1, 0, 16'h0000, 0, 0, 0, 1, 16'h0101, 1, 16'h0100, 1, S_RUN,  32'hB000_0100);

        foreach (vecs[i]) begin
            drive(vecs[i].rn, vecs[i].jv, vecs[i].jt, vecs[i].jr, vecs[i].hl, vecs[i].rs, vecs[i].rdy);
            check_all(i, vecs[i].e_pc, vecs[i].e_erm, vecs[i].e_irpc, vecs[i].e_iv, vecs[i].e_st, vecs[i].e_ir);
        end

        // pc wrap in BROM: fetch at 0xFFFF lands pc on 0x0000
        drive(1, 1, 16'hFFFF, 0, 0, 0, 1);
        check_all(100, 16'hFFFF, 0, 16'h0100, 0, S_RUN, 32'hB000_0100);
        drive(1, 0, 16'h0000, 0, 0, 0, 1);
        check_all(101, 16'h0000, 0, 16'hFFFF, 1, S_RUN, 32'hA000_FFFF);
        drive(1, 0, 16'h0000, 0, 0, 0, 1);
        check_all(102, 16'h0001, 0, 16'h0000, 1, S_RUN, 32'hA000_0000);

        // pc wrap in RAM keeps the RAM space selected
        drive(1, 1, 16'hFFFF, 1, 0, 0, 1);
        check_all(103, 16'hFFFF, 1, 16'h0000, 0, S_RUN, 32'hA000_0000);
        drive(1, 0, 16'h0000, 0, 0, 0, 1);
        check_all(104, 16'h0000, 1, 16'hFFFF, 1, S_RUN, 32'hB000_FFFF);
        drive(1, 0, 16'h0000, 0, 0, 0, 1);
        check_all(105, 16'h0001, 1, 16'h0000, 1, S_RUN, 32'hB000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
